// File: rtl/axi_arbiter_if.sv
// axi_arbiter_if: single-beat AXI4 master bus (AR/R/AW/W/B) between the arbiter and the system slave.
interface axi_arbiter_if;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    modport master (
        output awvalid, awaddr, awsize, wvalid, wdata, wstrb, bready, arvalid, araddr, arsize, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
    modport slave (
        input  awvalid, awaddr, awsize, wvalid, wdata, wstrb, bready, arvalid, araddr, arsize, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_arbiter.sv
// axi_arbiter: shares one AXI4 master port between IFU fetch and LSU load/store, one single-beat transaction at a time.
// Define AXI_ARB_RR_EN for round-robin arbitration; otherwise fixed priority set by LSU_FIRST.
module axi_arbiter #(
    parameter bit LSU_FIRST = 1'b1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          ifu_req_valid,
    output logic          ifu_req_ready,
    input  logic [31:0]   ifu_addr,
    output logic          ifu_rsp_valid,
    input  logic          lsu_req_valid,
    output logic          lsu_req_ready,
    input  logic          lsu_wen,
    input  logic [31:0]   lsu_addr,
    input  logic [31:0]   lsu_wdata,
    input  logic [3:0]    lsu_wstrb,
    input  logic [2:0]    lsu_size,
    output logic          lsu_rsp_valid,
    output logic [31:0]   rsp_data,
    output logic          rsp_err,
    axi_arbiter_if.master io_master
);
    typedef enum logic [2:0] {IDLE, AR, R, WR, B} state_t;
    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rsp_data_q, rsp_data_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [2:0]  size_q, size_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        ifu_rsp_q, ifu_rsp_d, lsu_rsp_q, lsu_rsp_d, rsp_err_q, rsp_err_d;
    logic        lsu_win, accept, done;

`ifdef AXI_ARB_RR_EN
    logic last_q;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) last_q <= 1'b0;
        else if (accept) last_q <= lsu_win;
    assign lsu_win = lsu_req_valid & (~ifu_req_valid | ~last_q);
`else
    assign lsu_win = lsu_req_valid & (~ifu_req_valid | LSU_FIRST);
`endif

    // ready is gated by reset_n so it drops the moment reset asserts, not at the next edge
    assign accept        = reset_n & (state_q == IDLE) & (ifu_req_valid | lsu_req_valid);
    assign ifu_req_ready = accept & ~lsu_win;
    assign lsu_req_ready = accept & lsu_win;
    assign done          = ((state_q == R) & io_master.rvalid) | ((state_q == B) & io_master.bvalid);

    assign io_master.arvalid = state_q == AR;
    assign io_master.rready  = state_q == R;
    assign io_master.awvalid = (state_q == WR) & ~aw_done_q;
    assign io_master.wvalid  = (state_q == WR) & ~w_done_q;
    assign io_master.bready  = state_q == B;
    assign io_master.araddr  = addr_q;
    assign io_master.awaddr  = addr_q;
    assign io_master.arsize  = size_q;
    assign io_master.awsize  = size_q;
    assign io_master.wdata   = wdata_q;
    assign io_master.wstrb   = wstrb_q;
    assign ifu_rsp_valid     = ifu_rsp_q;
    assign lsu_rsp_valid     = lsu_rsp_q;
    assign rsp_data          = rsp_data_q;
    assign rsp_err           = rsp_err_q;

    always_comb begin
        owner_d    = accept ? lsu_win : owner_q;
        addr_d     = accept ? (lsu_win ? lsu_addr : ifu_addr) : addr_q;
        size_d     = accept ? (lsu_win ? lsu_size : 3'd2) : size_q;
        wdata_d    = accept & lsu_win ? lsu_wdata : wdata_q;
        wstrb_d    = accept & lsu_win ? lsu_wstrb : wstrb_q;
        aw_done_d  = ~accept & (aw_done_q | (io_master.awvalid & io_master.awready));
        w_done_d   = ~accept & (w_done_q | (io_master.wvalid & io_master.wready));
        ifu_rsp_d  = done & ~owner_q;
        lsu_rsp_d  = done & owner_q;
        rsp_data_d = done ? ((state_q == R) ? io_master.rdata : 32'd0) : rsp_data_q;
        rsp_err_d  = done ? (((state_q == R) ? io_master.rresp : io_master.bresp) != 2'b00) : rsp_err_q;
        state_d    = state_q;
        if (accept) state_d = (lsu_win & lsu_wen) ? WR : AR;
        if ((state_q == AR) & io_master.arready) state_d = R;
        if ((state_q == WR) & aw_done_d & w_done_d) state_d = B;
        if (done) state_d = IDLE;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            size_q     <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            ifu_rsp_q  <= 1'b0;
            lsu_rsp_q  <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            size_q     <= size_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            ifu_rsp_q  <= ifu_rsp_d;
            lsu_rsp_q  <= lsu_rsp_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end
endmodule
